// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet reader.
//   PktCntW   : width of the completed-packet counter
//   XorMaxW   : widest word pkt_xor accepts (DataWidth must not exceed it)
//   state_t   : reader FSM state with StIdle / StStream / StCsum encodings
//   pkt_xor() : checksum accumulate step
package fifo_pkt_pkg;

  localparam int unsigned PktCntW = 16;
  localparam int unsigned XorMaxW = 64;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StStream = 2'd1;
  localparam state_t StCsum   = 2'd2;

  function automatic logic [XorMaxW-1:0] pkt_xor(input logic [XorMaxW-1:0] acc,
                                                 input logic [XorMaxW-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/fifo_pkt_reader_skid.sv
// Two-entry register FIFO that absorbs words returning from the upstream FIFO
// while the downstream side is stalled.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i        : write push_data_i into the tail entry
//   pop_i         : retire the head entry
//   occ_o         : number of valid entries (0..2)
//   head_o        : oldest valid entry
module pkt_skid_buf
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [1:0]           occ_o,
  output logic [DataWidth-1:0] head_o
);

  logic [DataWidth-1:0] mem_q [2];
  logic [DataWidth-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

  push_no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> (occ_q != 2'd2));
  pop_not_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> (occ_q != 2'd0));

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a single-clock FIFO and streams its words downstream over valid/ready,
// framing every PktLen payload words as a packet followed by an XOR checksum word.
//   clk_i, rst_ni     : clock, async active-low reset
//   enable_i          : permits new FIFO reads (words already requested still drain)
//   fifo_empty_ni     : FIFO Empty_ flag, low when empty
//   fifo_error_i      : FIFO error report, latched into error_sticky_o
//   fifo_data_out_i   : FIFO read data, valid the cycle after fifo_read_en_o
//   fifo_read_en_o    : FIFO read strobe
//   out_valid_o/out_ready_i/out_data_o : downstream stream
//   out_sop_o         : first payload word of a packet
//   out_eop_o         : checksum word (last word of a packet)
//   pkt_count_o       : completed packets, wrapping
//   error_sticky_o    : latched FIFO error, cleared by clear_err_i (set wins)
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DataWidth = 8,  // at most XorMaxW
  parameter int unsigned PktLen    = 4   // 1..255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 fifo_empty_ni,
  input  logic                 fifo_error_i,
  input  logic [DataWidth-1:0] fifo_data_out_i,
  output logic                 fifo_read_en_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_sop_o,
  output logic                 out_eop_o,
  output logic [PktCntW-1:0]   pkt_count_o,
  output logic                 error_sticky_o,
  input  logic                 clear_err_i
);

  localparam int unsigned CntW = 8;

  state_t               state_q, state_d;
  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]      out_cnt_q, out_cnt_d;
  logic [DataWidth-1:0] csum_q, csum_d;
  logic [PktCntW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                 inflight_q;
  logic                 err_q, err_d;

  logic [1:0]           occ;
  logic [DataWidth-1:0] head;
  logic [2:0]           slots_used;
  logic                 read_en;
  logic                 pop;
  logic                 last_payload;
  logic [DataWidth-1:0] csum_next;

  pkt_skid_buf #(
    .DataWidth (DataWidth)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_out_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

  // A requested word needs a buffer slot reserved before the read is issued,
  // so buffered plus in-flight words may never exceed the two entries.
  assign slots_used = {1'b0, occ} + {2'b00, inflight_q};

  // Gated by reset so the strobe reads 0 as soon as reset is asserted.
  assign read_en = rst_ni & enable_i & fifo_empty_ni & (rd_cnt_q < CntW'(PktLen))
                 & (slots_used < 3'd2);

  assign pop          = (state_q == StStream) & (occ != 2'd0) & out_ready_i;
  assign last_payload = (out_cnt_q == CntW'(PktLen - 1));
  assign csum_next    = DataWidth'(pkt_xor(XorMaxW'(csum_q), XorMaxW'(head)));

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    csum_d    = csum_q;
    pkt_cnt_d = pkt_cnt_q;
    if (read_en) begin
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (read_en) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (pop) begin
          csum_d    = csum_next;
          out_cnt_d = out_cnt_q + CntW'(1);
          if (last_payload) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (out_ready_i) begin
          state_d   = StIdle;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          csum_d    = '0;
          pkt_cnt_d = pkt_cnt_q + PktCntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Set has priority over clear.
  assign err_d = fifo_error_i | (err_q & ~clear_err_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      csum_q     <= '0;
      pkt_cnt_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      csum_q     <= csum_d;
      pkt_cnt_q  <= pkt_cnt_d;
      inflight_q <= read_en;
      err_q      <= err_d;
    end
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_sop_o   = 1'b0;
    out_eop_o   = 1'b0;
    unique case (state_q)
      StStream: begin
        out_valid_o = (occ != 2'd0);
        out_data_o  = head;
        out_sop_o   = (occ != 2'd0) & (out_cnt_q == '0);
      end
      StCsum: begin
        out_valid_o = 1'b1;
        out_data_o  = csum_q;
        out_eop_o   = 1'b1;
      end
      default: begin
        out_valid_o = 1'b0;
      end
    endcase
  end

  assign fifo_read_en_o = read_en;
  assign pkt_count_o    = pkt_cnt_q;
  assign error_sticky_o = err_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;

  localparam int PL = 4;
  localparam int FifoDepth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty_n = 1'b0;
  logic        fifo_error = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_read_en;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] pkt_count;
  logic        error_sticky;
  logic        clear_err = 1'b0;

  fifo_pkt_reader #(
    .DataWidth (8),
    .PktLen    (PL)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .fifo_empty_ni   (fifo_empty_n),
    .fifo_error_i    (fifo_error),
    .fifo_data_out_i (fifo_dout),
    .fifo_read_en_o  (fifo_read_en),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_data_o      (out_data),
    .out_sop_o       (out_sop),
    .out_eop_o       (out_eop),
    .pkt_count_o     (pkt_count),
    .error_sticky_o  (error_sticky),
    .clear_err_i     (clear_err)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic [31:0] w;     // payload, byte 0 written first
    logic [7:0]  csum;
    int          mode;  // 0: ready=1, 1: ready 1,0,0,1..., 2: random ready
    bit          drn;   // drain after writing this packet
  } pvec_t;

  typedef struct {
    logic err;
    logic clr;
    logic exp;
  } evec_t;

  int total = 0;
  int bad = 0;

  // Upstream FIFO model and expected-stream model.
  logic [7:0] fifo_q[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_s = 1'b0, wr_s = 1'b0;
  logic [7:0] wd_s = 8'h00;
  int         underflow = 0;

  beat_t      exp_q[$];
  int         grp_n = 0;
  logic [7:0] grp_x = 8'h00;
  logic [7:0] csum_seen[$];
  int         pkt_exp = 0;
  int         xfers = 0;
  int         rd_issues = 0;
  logic       prev_stall = 1'b0;
  beat_t      prev_b = '0;
  logic       rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packetisation rule: words leave in write order, each group of PL words
  // gets Sop on its first word and is followed by the XOR of the group.
  task automatic model_push(input logic [7:0] w);
    exp_q.push_back({w, (grp_n == 0), 1'b0});
    grp_x ^= w;
    grp_n++;
    if (grp_n == PL) begin
      exp_q.push_back({grp_x, 1'b0, 1'b1});
      grp_n = 0;
      grp_x = 8'h00;
    end
  endtask

  // After a reset the partial packet is gone; whatever is still stored in
  // the FIFO becomes the start of a fresh packet.
  task automatic model_reset();
    exp_q.delete();
    grp_n = 0;
    grp_x = 8'h00;
    foreach (fifo_q[i]) model_push(fifo_q[i]);
  endtask

  task automatic monitor();
    beat_t e;
    rd_s = fifo_read_en;
    wr_s = wr_en;
    wd_s = wr_data;
    if (!rst_n) begin
      prev_stall = 1'b0;
      pkt_exp    = 0;
      return;
    end
    if (rd_s) rd_issues++;
    if (!fifo_empty_n) chk("read_when_empty", 32'(fifo_read_en), 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(prev_b.d));
      chk("hold_sop", 32'(out_sop), 32'(prev_b.sop));
      chk("hold_eop", 32'(out_eop), 32'(prev_b.eop));
    end
    chk("pkt_count", 32'(pkt_count), 32'(pkt_exp));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got %0h expected no beat at %0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(out_data), 32'(e.d));
        chk("beat_sop", 32'(out_sop), 32'(e.sop));
        chk("beat_eop", 32'(out_eop), 32'(e.eop));
      end
      xfers++;
      if (out_eop) begin
        pkt_exp++;
        csum_seen.push_back(out_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_b     = {out_data, out_sop, out_eop};
  endtask

  // One clock: check at the falling edge, update the FIFO model at the rising
  // edge, then return 10 ns later so new stimulus is applied away from edges.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    if (rd_s) begin
      if (fifo_q.size() == 0) underflow++;
      else fifo_dout <= fifo_q.pop_front();
    end
    if (wr_s) fifo_q.push_back(wd_s);
    fifo_empty_n <= (fifo_q.size() != 0);
    #10;
  endtask

  task automatic wr_word(input logic [7:0] w);
    for (int k = 0; k < 50 && fifo_q.size() >= FifoDepth; k++) tick();
    wr_en   = 1'b1;
    wr_data = w;
    model_push(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int mode);
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      case (mode)
        1:       out_ready = rp[k % 4];
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
  endtask

  task automatic chk_csum(input string name, input logic [7:0] exp);
    chk({name, "_cnt"}, 32'(csum_seen.size() != 0), 32'd1);
    if (csum_seen.size() != 0) chk(name, 32'(csum_seen.pop_front()), 32'(exp));
  endtask

  initial begin
    pvec_t tbl[6];
    evec_t etbl[8];
    int p, n0, x0;

    tbl[0] = '{32'h44332211, 8'h44, 0, 1'b1};
    tbl[1] = '{32'h04030201, 8'h04, 0, 1'b0};
    tbl[2] = '{32'h08070605, 8'h0C, 0, 1'b1};
    tbl[3] = '{32'h44332211, 8'h44, 1, 1'b1};
    tbl[4] = '{32'h55AA00FF, 8'h00, 2, 1'b1};
    tbl[5] = '{32'h80402010, 8'hF0, 1, 1'b1};

    etbl[0] = '{1'b0, 1'b0, 1'b0};
    etbl[1] = '{1'b1, 1'b0, 1'b1};
    etbl[2] = '{1'b0, 1'b0, 1'b1};
    etbl[3] = '{1'b0, 1'b0, 1'b1};
    etbl[4] = '{1'b0, 1'b1, 1'b0};
    etbl[5] = '{1'b1, 1'b1, 1'b1};
    etbl[6] = '{1'b0, 1'b0, 1'b1};
    etbl[7] = '{1'b0, 1'b1, 1'b0};

    // Reset state.
    enable = 1'b1;
    tick();
    tick();
    chk("rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_eop", 32'(out_eop), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err", 32'(error_sticky), 32'd0);
    rst_n = 1'b1;
    tick();

    // Error latch table.
    foreach (etbl[i]) begin
      fifo_error = etbl[i].err;
      clear_err  = etbl[i].clr;
      tick();
      chk("err_sticky", 32'(error_sticky), 32'(etbl[i].exp));
    end
    fifo_error = 1'b0;
    clear_err  = 1'b0;

    // Packet table.
    out_ready = 1'b1;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = (tbl[i].mode == 1) ? rp[0] : 1'b1;
      for (int k = 0; k < PL; k++) wr_word(tbl[i].w[8*k +: 8]);
      if (tbl[i].drn) begin
        drain(tbl[i].mode);
        for (int j = p; j <= i; j++) chk_csum("pkt_csum", tbl[j].csum);
        chk("pkt_count_tbl", 32'(pkt_count), 32'(i + 1));
        p = i + 1;
      end
    end

    // FIFO runs dry mid-packet.
    csum_seen.delete();
    x0 = xfers;
    wr_word(8'h11);
    wr_word(8'h22);
    for (int k = 0; k < 20; k++) tick();
    chk("dry_xfers", 32'(xfers - x0), 32'd2);
    chk("dry_valid", 32'(out_valid), 32'd0);
    chk("dry_eop_none", 32'(csum_seen.size()), 32'd0);
    wr_word(8'h33);
    wr_word(8'h44);
    drain(0);
    chk_csum("dry_csum", 8'h44);

    // Enable dropped after the second read issue.
    enable = 1'b0;
    for (int k = 0; k < PL; k++) wr_word(8'hA1 + 8'(k));
    tick();
    n0 = rd_issues;
    x0 = xfers;
    enable = 1'b1;
    for (int k = 0; k < 20 && rd_issues < n0 + 2; k++) tick();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("en_issues", 32'(rd_issues - n0), 32'd2);
    chk("en_xfers", 32'(xfers - x0), 32'd2);
    chk("en_valid", 32'(out_valid), 32'd0);
    drain(0);
    chk_csum("en_csum", 8'hA1 ^ 8'hA2 ^ 8'hA3 ^ 8'hA4);

    // Reset in the middle of a packet with words left in the FIFO.
    enable = 1'b0;
    for (int k = 0; k < 6; k++) wr_word(8'h51 + 8'(k));
    x0 = xfers;
    enable = 1'b1;
    for (int k = 0; k < 30 && xfers < x0 + 2; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sop", 32'(out_sop), 32'd0);
    chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    while (grp_n != 0) wr_word(8'($urandom));
    drain(0);
    chk("post_rst_pkts", 32'(pkt_count), 32'(pkt_exp));

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < FifoDepth - 1) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        model_push(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    while (grp_n != 0) wr_word(8'($urandom));
    drain(0);

    chk("fifo_underflow", 32'(underflow), 32'd0);
    chk("final_err", 32'(error_sticky), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
